// File: rtl/l1_trigger_packetizer_v3.sv
// Beam trigger packetizer: masks and holds off per-cycle beam triggers, timestamps and sequences
// accepted events, queues them in an event FIFO and serializes each as NW words on an AXI4-Stream port.
module l1_trigger_packetizer_v3 #(
    parameter int NBEAMS       = 48,
    parameter int TS_BITS      = 16,
    parameter int HOLDOFF_BITS = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                    ifclk,
    input  logic                    ifclk_rst_i,
    input  logic [NBEAMS-1:0]       trig_i,
    input  logic [NBEAMS-1:0]       beam_mask_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    runrst_i,
    input  logic                    runstop_i,
    output logic [31:0]             m_trig_tdata,
    output logic                    m_trig_tvalid,
    input  logic                    m_trig_tready,
    output logic                    running_o,
    output logic                    overflow_o,
    output logic [15:0]             drop_count_o
);
    localparam int SEQ_BITS = 32 - TS_BITS;
    localparam int NBW      = (NBEAMS + 31) / 32;
    localparam int NW       = 1 + NBW;
    localparam int BMW      = 32 * NBW;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int WIW      = $clog2(NW);
    localparam logic [WIW-1:0] C_LAST  = WIW'(NW - 1);
    localparam logic [AW:0]    C_DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_STOP, ST_RUN} state_t;
    state_t r_state, w_state_nxt;

    logic [TS_BITS-1:0]      r_ts;
    logic [SEQ_BITS-1:0]     r_seq;
    logic [HOLDOFF_BITS-1:0] r_holdoff;
    logic [NBEAMS-1:0]       w_bits;
    logic                    w_accept;

    logic                    r_cap_vld;
    logic [31:0]             r_cap_w0;
    logic [NBEAMS-1:0]       r_cap_bits;

    logic [31:0]             r_mem_w0   [FIFO_DEPTH];
    logic [NBEAMS-1:0]       r_mem_bits [FIFO_DEPTH];
    logic [AW:0]             r_wr_ptr, r_rd_ptr, w_count;
    logic [AW-1:0]           w_rd_idx, w_head_idx;
    logic                    w_full, w_wr, w_pop, w_drop, w_avail, w_adv;
    logic [BMW-1:0]          w_head_pad;

    logic                    r_tvalid, r_owns;
    logic [31:0]             r_tdata;
    logic [WIW-1:0]          r_widx;
    logic [BMW-1:0]          r_cur_bits;
    logic                    r_overflow;
    logic [15:0]             r_drop_cnt;

    always_comb begin
        w_state_nxt = r_state;
        if (runrst_i)
            w_state_nxt = ST_RUN;
        else if (runstop_i)
            w_state_nxt = ST_STOP;
    end

    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i)
            r_state <= ST_STOP;
        else
            r_state <= w_state_nxt;
    end

    assign w_bits   = trig_i & ~beam_mask_i;
    assign w_accept = (r_state == ST_RUN) && !runrst_i && (|w_bits) && (r_holdoff == '0);

    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i || runrst_i) begin
            r_ts      <= '0;
            r_seq     <= '0;
            r_holdoff <= '0;
            r_cap_vld <= 1'b0;
        end else begin
            if (r_state == ST_RUN)
                r_ts <= r_ts + 1'b1;
            r_cap_vld <= w_accept;
            if (w_accept) begin
                r_seq      <= r_seq + 1'b1;
                r_holdoff  <= holdoff_i;
                r_cap_w0   <= {r_seq, r_ts};
                r_cap_bits <= w_bits;
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - 1'b1;
            end
        end
    end

    // The event being serialized stays at the FIFO head until its last word is taken,
    // so it occupies a slot; r_owns drops when a run reset orphans it from the queue.
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_count == C_DEPTH);
    assign w_rd_idx   = r_rd_ptr[AW-1:0];
    assign w_adv      = !r_tvalid || m_trig_tready;
    assign w_pop      = r_tvalid && m_trig_tready && (r_widx == C_LAST) && r_owns;
    assign w_wr       = r_cap_vld && (!w_full || w_pop);
    assign w_drop     = r_cap_vld && w_full && !w_pop;
    assign w_head_idx = w_pop ? (w_rd_idx + AW'(1)) : w_rd_idx;
    assign w_avail    = w_pop ? (w_count >= (AW + 1)'(2)) : (w_count != '0);

    always_comb begin
        w_head_pad = '0;
        w_head_pad[NBEAMS-1:0] = r_mem_bits[w_head_idx];
    end

    always_ff @(posedge ifclk) begin
        if (w_wr) begin
            r_mem_w0[r_wr_ptr[AW-1:0]]   <= r_cap_w0;
            r_mem_bits[r_wr_ptr[AW-1:0]] <= r_cap_bits;
        end
    end

    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i || runrst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF)
                    r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i) begin
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_widx     <= '0;
            r_owns     <= 1'b0;
            r_cur_bits <= '0;
        end else begin
            if (w_adv) begin
                if (r_tvalid && (r_widx != C_LAST)) begin
                    r_tdata <= r_cur_bits[32*int'(r_widx) +: 32];
                    r_widx  <= r_widx + WIW'(1);
                end else if (w_avail && !runrst_i) begin
                    r_tdata    <= r_mem_w0[w_head_idx];
                    r_cur_bits <= w_head_pad;
                    r_widx     <= '0;
                    r_tvalid   <= 1'b1;
                    r_owns     <= 1'b1;
                end else begin
                    r_tvalid <= 1'b0;
                    r_owns   <= 1'b0;
                end
            end
            if (runrst_i)
                r_owns <= 1'b0;
        end
    end

    assign m_trig_tdata  = r_tdata;
    assign m_trig_tvalid = r_tvalid;
    assign running_o     = (r_state == ST_RUN);
    assign overflow_o    = r_overflow;
    assign drop_count_o  = r_drop_cnt;

endmodule

// File: tb/tb_l1_trigger_packetizer_v3.sv
// Scoreboard bench for l1_trigger_packetizer_v3 (NBEAMS=48, TS_BITS=8): stimulus pushes expected
// stream words, a negedge monitor pops and compares them on every handshake.
module tb_l1_trigger_packetizer_v3;
    logic        clk = 1'b0;
    logic        ifclk_rst_i;
    logic [47:0] trig_i, beam_mask_i;
    logic [7:0]  holdoff_i;
    logic        runrst_i, runstop_i, m_trig_tready;
    logic [31:0] m_trig_tdata;
    logic        m_trig_tvalid, running_o, overflow_o;
    logic [15:0] drop_count_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];
    int m_ts = 0;
    bit m_run = 1'b0;
    logic [47:0] pats [6];

    always #5 clk = ~clk;

    l1_trigger_packetizer_v3 #(
        .NBEAMS(48), .TS_BITS(8), .HOLDOFF_BITS(8), .FIFO_DEPTH(16)
    ) dut (
        .ifclk(clk), .ifclk_rst_i(ifclk_rst_i), .trig_i(trig_i), .beam_mask_i(beam_mask_i),
        .holdoff_i(holdoff_i), .runrst_i(runrst_i), .runstop_i(runstop_i),
        .m_trig_tdata(m_trig_tdata), .m_trig_tvalid(m_trig_tvalid), .m_trig_tready(m_trig_tready),
        .running_o(running_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_event(input int unsigned seq, input int ts, input logic [47:0] bits);
        logic [31:0] s;
        logic [31:0] t;
        s = seq;
        t = ts;
        q.push_back({s[23:0], t[7:0]});
        q.push_back(bits[31:0]);
        q.push_back({16'h0, bits[47:32]});
    endtask

    // Timestamp model tracked alongside the DUT clock.
    task automatic step();
        if (ifclk_rst_i) begin
            m_ts = 0; m_run = 1'b0;
        end else if (runrst_i) begin
            m_ts = 0; m_run = 1'b1;
        end else begin
            if (m_run) m_ts = (m_ts + 1) % 256;
            if (runstop_i) m_run = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_reset();
        runrst_i = 1'b1;
        step();
        runrst_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        m_trig_tready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (q.size() == 0 && !m_trig_tvalid) break;
            step();
        end
        check(name, q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!ifclk_rst_i && m_trig_tvalid) begin
            if (m_trig_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word actual=%h required=none", m_trig_tdata);
                end else begin
                    check("stream_word", m_trig_tdata, q.pop_front());
                end
            end else if (q.size() != 0) begin
                check("stall_hold", m_trig_tdata, q[0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pats[0] = 48'hA5A5_0000_0001;
        pats[1] = 48'h8000_0000_0000;
        pats[2] = 48'hFFFF_FFFF_FFFF;
        pats[3] = 48'h0001_0000_0000;
        pats[4] = 48'h0000_8000_0000;
        pats[5] = 48'h1234_5678_9ABC;

        ifclk_rst_i = 1'b1; trig_i = '0; beam_mask_i = '0; holdoff_i = '0;
        runrst_i = 1'b0; runstop_i = 1'b0; m_trig_tready = 1'b1;
        repeat (3) step();
        ifclk_rst_i = 1'b0;
        step();
        check("rst_tvalid", 32'(m_trig_tvalid), 0);
        check("rst_tdata", m_trig_tdata, 0);
        check("rst_running", 32'(running_o), 0);
        check("rst_overflow", 32'(overflow_o), 0);
        check("rst_drops", 32'(drop_count_o), 0);

        // basic event at ts=5 and its latency
        run_reset();
        check("run_after_runrst", 32'(running_o), 1);
        repeat (5) step();
        push_event(0, 5, 48'h1);
        trig_i = 48'h1;
        step();
        trig_i = '0;
        check("lat_n1", 32'(m_trig_tvalid), 0);
        step();
        check("lat_n2", 32'(m_trig_tvalid), 0);
        step();
        check("lat_n3", 32'(m_trig_tvalid), 1);
        wait_drain("drain_basic");

        // masking
        beam_mask_i = 48'h1;
        trig_i = 48'h1;
        step();
        trig_i = '0;
        repeat (4) step();
        check("mask_no_event", 32'(m_trig_tvalid), 0);
        push_event(1, m_ts, 48'h2);
        trig_i = 48'h3;
        step();
        trig_i = '0;
        beam_mask_i = '0;
        wait_drain("drain_mask");

        // holdoff of 4: accepts on burst cycles 0 and 5
        run_reset();
        holdoff_i = 8'd4;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) push_event(0, m_ts, 48'h1);
            if (i == 5) push_event(1, m_ts, 48'h1);
            trig_i = 48'h1;
            step();
        end
        trig_i = '0;
        holdoff_i = '0;
        wait_drain("drain_holdoff");

        // overflow: 20 events into 16 slots with the stream stalled
        run_reset();
        m_trig_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) push_event(i, m_ts, 48'h1);
            trig_i = 48'h1;
            step();
        end
        trig_i = '0;
        repeat (3) step();
        check("ovf_flag", 32'(overflow_o), 1);
        check("ovf_drops", 32'(drop_count_o), 4);
        wait_drain("drain_ovf");
        check("ovf_sticky", 32'(overflow_o), 1);
        run_reset();
        check("ovf_cleared", 32'(overflow_o), 0);
        check("drops_cleared", 32'(drop_count_o), 0);

        // random backpressure, then stop mid-burst
        run_reset();
        for (int k = 0; k < 6; k++) begin
            m_trig_tready = 1'($urandom_range(0, 1));
            push_event(k, m_ts, pats[k]);
            trig_i = pats[k];
            step();
        end
        trig_i = '0;
        runstop_i = 1'b1;
        step();
        runstop_i = 1'b0;
        check("stopped", 32'(running_o), 0);
        for (int k = 0; k < 5; k++) begin
            m_trig_tready = 1'($urandom_range(0, 1));
            trig_i = '1;
            step();
        end
        trig_i = '0;
        for (int k = 0; k < 30; k++) begin
            m_trig_tready = 1'($urandom_range(0, 1));
            step();
        end
        wait_drain("drain_stop");
        check("still_stopped", 32'(running_o), 0);
        runrst_i = 1'b1;
        runstop_i = 1'b1;
        step();
        runrst_i = 1'b0;
        runstop_i = 1'b0;
        check("runrst_wins", 32'(running_o), 1);

        // timestamp wrap with 24-bit sequence field
        run_reset();
        repeat (255) step();
        push_event(0, 255, 48'h4);
        trig_i = 48'h4;
        step();
        push_event(1, 0, 48'h0000_8000_0000);
        trig_i = 48'h0000_8000_0000;
        step();
        trig_i = '0;
        wait_drain("drain_wrap");

        // hard reset while an event is on the stream
        m_trig_tready = 1'b0;
        push_event(2, m_ts, 48'h10);
        trig_i = 48'h10;
        step();
        trig_i = '0;
        for (int i = 0; i < 10; i++) begin
            if (m_trig_tvalid) break;
            step();
        end
        check("pre_abort_tvalid", 32'(m_trig_tvalid), 1);
        ifclk_rst_i = 1'b1;
        step();
        check("abort_tvalid", 32'(m_trig_tvalid), 0);
        q.delete();
        ifclk_rst_i = 1'b0;
        m_trig_tready = 1'b1;
        repeat (4) step();
        check("abort_idle", 32'(m_trig_tvalid), 0);
        check("abort_running", 32'(running_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
